// File: rtl/slice_line_buffer_pkg.sv
// Shared definitions for the slice line buffer.
//   state_e        : sequencer phase encoding (IDLE, LOAD, RUN, DRAIN)
//   DEFAULT_LINE_W : default bits per line (one slice)
//   DEFAULT_DEPTH  : default number of lines held by the buffer
package slice_line_buffer_pkg;

    localparam int DEFAULT_LINE_W = 25;
    localparam int DEFAULT_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/slice_line_buffer_mem.sv
// DEPTH x LINE_W line store: one synchronous write port, two asynchronous
// read ports. Addresses at or beyond DEPTH (possible when DEPTH is not a
// power of two) read as zero and never write.
//   clk        : write clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_a_i  : read port A address, rdata_a_o combinational result
//   raddr_b_i  : read port B address, rdata_b_o combinational result
module slice_mem_2r1w
    import slice_line_buffer_pkg::*;
#(
    parameter int  LINE_W = DEFAULT_LINE_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [LINE_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [LINE_W-1:0] rdata_b_o
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [LINE_W-1:0] mem_q [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    // NOTE: the array has no reset branch; clearing a RAM costs a write per
    // entry and the contents are always rewritten by a load before use.
    always_ff @(posedge clk) begin
        if (we_i && in_range(waddr_i)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = in_range(raddr_a_i) ? mem_q[raddr_a_i] : '0;
    assign rdata_b_o = in_range(raddr_b_i) ? mem_q[raddr_b_i] : '0;

endmodule

// File: rtl/slice_line_buffer.sv
// Line store and sequencer between the host stream and the slice engine.
// A pass runs LOAD (DEPTH lines in), RUN (engine random access), DRAIN
// (DEPTH lines out in order).
//   clk, rst              : clock, synchronous active-high reset
//   start                 : begin a load phase (IDLE only)
//   in_valid/in_data/in_ready            : load stream
//   eng_start             : one-cycle pulse, buffer full
//   eng_addr/eng_rd_cur/eng_rd_prev      : engine read of a line and its
//                                          cyclic predecessor
//   eng_we/eng_wdata      : engine write
//   eng_done              : engine finished (RUN only)
//   out_valid/out_data/out_ready/out_last: drain stream
//   busy, done, count     : status; count = lines moved in current phase
// DEPTH must be at least 2.
module slice_line_buffer
    import slice_line_buffer_pkg::*;
#(
    parameter int  LINE_W = DEFAULT_LINE_W,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [LINE_W-1:0] in_data,
    output logic              in_ready,
    output logic              eng_start,
    input  logic [AW-1:0]     eng_addr,
    output logic [LINE_W-1:0] eng_rd_cur,
    output logic [LINE_W-1:0] eng_rd_prev,
    input  logic              eng_we,
    input  logic [LINE_W-1:0] eng_wdata,
    input  logic              eng_done,
    output logic              out_valid,
    output logic [LINE_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [AW:0]       count
);

    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LAST_IDX   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   PENULT_IDX = (AW+1)'(DEPTH - 2);
    localparam logic [AW-1:0] TOP_ADDR   = AW'(DEPTH - 1);

    state_e      state_q;
    logic [AW:0] count_q;
    logic        in_ready_q;
    logic        eng_start_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic        done_q;

    logic              eng_in_range;
    logic [AW-1:0]     prev_addr;
    logic [AW-1:0]     rd_a_addr;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] rd_a_data;
    logic [LINE_W-1:0] rd_b_data;

    // An out-of-range engine address keeps the predecessor out of range too,
    // so both engine reads return zero.
    assign eng_in_range = ({1'b0, eng_addr} < DEPTH_W);
    assign prev_addr    = !eng_in_range      ? eng_addr :
                          (eng_addr == '0)   ? TOP_ADDR :
                                               eng_addr - AW'(1);

    // Port A serves the engine outside DRAIN and the drain stream in DRAIN;
    // the engine is idle while draining.
    assign rd_a_addr = (state_q == DRAIN) ? count_q[AW-1:0] : eng_addr;

    // The write port is owned by the load stream in LOAD and the engine in RUN.
    assign mem_we    = ((state_q == LOAD) && in_valid && in_ready_q) ||
                       ((state_q == RUN)  && eng_we);
    assign mem_waddr = (state_q == LOAD) ? count_q[AW-1:0] : eng_addr;
    assign mem_wdata = (state_q == LOAD) ? in_data : eng_wdata;

    slice_mem_2r1w #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .we_i      (mem_we),
        .waddr_i   (mem_waddr),
        .wdata_i   (mem_wdata),
        .raddr_a_i (rd_a_addr),
        .rdata_a_o (rd_a_data),
        .raddr_b_i (prev_addr),
        .rdata_b_o (rd_b_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (count_q == LAST_IDX) begin
                            state_q     <= RUN;
                            count_q     <= '0;
                            in_ready_q  <= 1'b0;
                            eng_start_q <= 1'b1;
                        end else begin
                            count_q <= count_q + (AW+1)'(1);
                        end
                    end
                end
                RUN: begin
                    if (eng_done) begin
                        state_q     <= DRAIN;
                        count_q     <= '0;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            count_q     <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            count_q    <= count_q + (AW+1)'(1);
                            out_last_q <= (count_q == PENULT_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign eng_start   = eng_start_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign count       = count_q;
    assign eng_rd_cur  = rd_a_data;
    assign eng_rd_prev = rd_b_data;
    assign out_data    = out_valid_q ? rd_a_data : '0;

endmodule

// File: tb/tb_slice_line_buffer.sv
// Self-checking bench: default instance (25 x 64) with a scoreboard on the
// drain stream, plus a non-power-of-two instance (8 x 5) checked directly.
module tb_slice_line_buffer;

    localparam int LW  = 25;
    localparam int D   = 64;
    localparam int AWA = 6;
    localparam int LWB = 8;
    localparam int DB  = 5;
    localparam int AWB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // default instance
    logic           start_a, in_valid_a, in_ready_a, eng_start_a;
    logic [LW-1:0]  in_data_a, rd_cur_a, rd_prev_a, eng_wdata_a, out_data_a;
    logic [AWA-1:0] eng_addr_a;
    logic           eng_we_a, eng_done_a, out_valid_a, out_ready_a, out_last_a;
    logic           busy_a, done_a;
    logic [AWA:0]   count_a;

    // small instance
    logic           start_b, in_valid_b, in_ready_b, eng_start_b;
    logic [LWB-1:0] in_data_b, rd_cur_b, rd_prev_b, eng_wdata_b, out_data_b;
    logic [AWB-1:0] eng_addr_b;
    logic           eng_we_b, eng_done_b, out_valid_b, out_ready_b, out_last_b;
    logic           busy_b, done_b;
    logic [AWB:0]   count_b;

    slice_line_buffer dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .in_valid(in_valid_a), .in_data(in_data_a), .in_ready(in_ready_a),
        .eng_start(eng_start_a), .eng_addr(eng_addr_a),
        .eng_rd_cur(rd_cur_a), .eng_rd_prev(rd_prev_a),
        .eng_we(eng_we_a), .eng_wdata(eng_wdata_a), .eng_done(eng_done_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready_a),
        .out_last(out_last_a), .busy(busy_a), .done(done_a), .count(count_a)
    );

    slice_line_buffer #(.LINE_W(LWB), .DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .eng_start(eng_start_b), .eng_addr(eng_addr_b),
        .eng_rd_cur(rd_cur_b), .eng_rd_prev(rd_prev_b),
        .eng_we(eng_we_b), .eng_wdata(eng_wdata_b), .eng_done(eng_done_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b),
        .out_last(out_last_b), .busy(busy_b), .done(done_b), .count(count_b)
    );

    typedef struct {
        logic [LW-1:0] data;
        logic          last;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            eng_start_cnt = 0;
    int            done_cnt = 0;
    int            es_base = 0;
    logic [LW-1:0] ref_mem [D];
    exp_t          exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every accepted drain beat must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (eng_start_a) eng_start_cnt++;
        if (done_a) done_cnt++;
        if (!rst && out_valid_a && out_ready_a) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL drain_unexpected: actual=%0h required=none", out_data_a);
            end else begin
                e = exp_q.pop_front();
                check("drain_data", 32'(out_data_a), 32'(e.data));
                check("drain_last", 32'(out_last_a), 32'(e.last));
            end
        end
    end

    task automatic idle_a();
        start_a = 0; in_valid_a = 0; in_data_a = '0; eng_addr_a = '0;
        eng_we_a = 0; eng_wdata_a = '0; eng_done_a = 0; out_ready_a = 0;
    endtask

    // All tasks begin and end one time unit after a rising edge.
    task automatic start_load();
        start_a = 1;
        @(posedge clk); #1;
        start_a = 0;
    endtask

    task automatic load_phase(input bit toggle, input bit rand_data);
        int            idx = 0;
        int            cyc = 0;
        bit            acc;
        logic [LW-1:0] v;
        es_base = eng_start_cnt;
        while (idx < D && cyc < 8 * D) begin
            in_valid_a = toggle ? (cyc % 2 == 0) : 1'b1;
            v = rand_data ? LW'($urandom) : LW'(idx);
            in_data_a = v;
            @(negedge clk);
            if (cyc == 0) check("load_busy", 32'(busy_a), 1);
            acc = in_valid_a && in_ready_a;
            if (acc) check("load_count", 32'(count_a), idx);
            @(posedge clk); #1;
            if (acc) begin
                ref_mem[idx] = v;
                idx++;
            end
            cyc++;
        end
        in_valid_a = 0;
        check("load_lines", idx, D);
        @(negedge clk);
        check("eng_start_pulse", 32'(eng_start_a), 1);
        check("run_in_ready", 32'(in_ready_a), 0);
        check("run_count", 32'(count_a), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_step(input int addr, input bit we, input logic [LW-1:0] wd, input bit fin);
        eng_addr_a = AWA'(addr); eng_we_a = we; eng_wdata_a = wd; eng_done_a = fin;
        @(negedge clk);
        check("rd_cur", 32'(rd_cur_a), 32'(ref_mem[addr]));
        check("rd_prev", 32'(rd_prev_a), 32'(ref_mem[(addr + D - 1) % D]));
        check("run_out_valid", 32'(out_valid_a), 0);
        @(posedge clk); #1;
        if (we) ref_mem[addr] = wd;
        eng_we_a = 0; eng_done_a = 0;
        if (fin) begin
            for (int i = 0; i < D; i++) exp_q.push_back('{data: ref_mem[i], last: (i == D - 1)});
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++)
            run_step($urandom_range(D - 1), 1'($urandom), LW'($urandom), i == n - 1);
    endtask

    task automatic drain_phase(input int stall_at, input int stall_len, input int rst_at,
                               input bit junk, input bit start_on_done);
        int n = 0;
        int cyc = 0;
        int stall = 0;
        int d0 = done_cnt;
        bit xfer;
        check("eng_start_once", eng_start_cnt, es_base + 1);
        while (n < D && cyc < 8 * D) begin
            out_ready_a = !(n == stall_at && stall < stall_len);
            if (junk) begin
                eng_we_a = 1; eng_done_a = 1; start_a = 1;
                eng_addr_a = AWA'($urandom_range(D - 1)); eng_wdata_a = LW'($urandom);
            end
            if (n == rst_at) begin
                rst = 1; out_ready_a = 0;
            end
            @(negedge clk);
            check("drain_count", 32'(count_a), n);
            if (!out_ready_a && !rst) begin
                check("stall_data", 32'(out_data_a), 32'(ref_mem[n]));
                check("stall_valid", 32'(out_valid_a), 1);
                stall++;
            end
            xfer = out_valid_a && out_ready_a;
            @(posedge clk); #1;
            if (rst) begin
                rst = 0;
                exp_q.delete();
                out_ready_a = 0;
                @(negedge clk);
                check("rst_busy", 32'(busy_a), 0);
                check("rst_out_valid", 32'(out_valid_a), 0);
                check("rst_out_last", 32'(out_last_a), 0);
                check("rst_in_ready", 32'(in_ready_a), 0);
                check("rst_done", 32'(done_a), 0);
                check("rst_count", 32'(count_a), 0);
                @(posedge clk); #1;
                return;
            end
            if (xfer) n++;
            cyc++;
        end
        idle_a();
        check("drain_lines", n, D);
        if (start_on_done) start_a = 1;
        @(negedge clk);
        check("done_pulse", 32'(done_a), 1);
        check("done_busy", 32'(busy_a), 0);
        check("done_out_valid", 32'(out_valid_a), 0);
        check("done_count", 32'(count_a), 0);
        @(posedge clk); #1;
        start_a = 0;
        @(negedge clk);
        check("done_cleared", 32'(done_a), 0);
        check("done_once", done_cnt, d0 + 1);
        check("restart_busy", 32'(busy_a), 32'(start_on_done));
        check("restart_in_ready", 32'(in_ready_a), 32'(start_on_done));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [LWB-1:0] exp_b [DB];
        int nb;
        int cyc;
        idle_a();
        start_b = 0; in_valid_b = 0; in_data_b = '0; eng_addr_b = '0;
        eng_we_b = 0; eng_wdata_b = '0; eng_done_b = 0; out_ready_b = 0;

        // reset and idle behaviour
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        in_valid_a = 1; in_data_a = 25'h1FFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", 32'(busy_a), 0);
            check("idle_in_ready", 32'(in_ready_a), 0);
            check("idle_out_valid", 32'(out_valid_a), 0);
            check("idle_count", 32'(count_a), 0);
            check("idle_pulses", 32'({eng_start_a, done_a, out_last_a}), 0);
            @(posedge clk); #1;
        end
        in_valid_a = 0;

        // pass 1: index data, directed wrap/write run
        start_load();
        load_phase(0, 0);
        run_step(0, 0, '0, 0);
        run_step(5, 1, 25'h0AAAAAA, 0);
        run_step(5, 0, '0, 0);
        run_step(63, 0, '0, 0);
        run_step(20, 1, LW'($urandom), 1);
        drain_phase(-1, 0, -1, 0, 0);

        // pass 2: valid toggling, random run, drain stall with ignored engine inputs
        start_load();
        load_phase(1, 1);
        run_random(30);
        drain_phase(20, 10, -1, 1, 0);

        // pass 3: reset in the middle of the drain
        start_load();
        load_phase(0, 1);
        run_random(8);
        drain_phase(-1, 0, 30, 0, 0);

        // pass 4: reload after reset, restart on the done cycle
        start_load();
        load_phase(0, 1);
        run_random(12);
        drain_phase(-1, 0, -1, 0, 1);

        // pass 5: load already started by the done-cycle start
        load_phase(1, 1);
        run_random(10);
        drain_phase(3, 4, -1, 0, 0);
        check("queue_empty", exp_q.size(), 0);

        // non-power-of-two instance
        start_b = 1;
        @(posedge clk); #1;
        start_b = 0;
        for (int i = 0; i < DB; i++) begin
            in_valid_b = 1; in_data_b = LWB'(8'h10 + i);
            @(negedge clk);
            check("b_in_ready", 32'(in_ready_b), 1);
            @(posedge clk); #1;
        end
        in_valid_b = 0;
        @(negedge clk);
        check("b_eng_start", 32'(eng_start_b), 1);
        @(posedge clk); #1;
        eng_addr_b = 3'd0;
        @(negedge clk);
        check("b_wrap_cur", 32'(rd_cur_b), 32'h10);
        check("b_wrap_prev", 32'(rd_prev_b), 32'h14);
        @(posedge clk); #1;
        eng_addr_b = 3'd6; eng_we_b = 1; eng_wdata_b = 8'hEE;
        @(negedge clk);
        check("b_oor_cur", 32'(rd_cur_b), 0);
        check("b_oor_prev", 32'(rd_prev_b), 0);
        @(posedge clk); #1;
        eng_we_b = 0; eng_addr_b = 3'd1;
        @(negedge clk);
        check("b_cur1", 32'(rd_cur_b), 32'h11);
        check("b_prev1", 32'(rd_prev_b), 32'h10);
        @(posedge clk); #1;
        eng_addr_b = 3'd4; eng_we_b = 1; eng_wdata_b = 8'h77; eng_done_b = 1;
        @(posedge clk); #1;
        eng_we_b = 0; eng_done_b = 0; out_ready_b = 1;
        exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h77};
        nb = 0; cyc = 0;
        while (nb < DB && cyc < 40) begin
            @(negedge clk);
            if (out_valid_b) begin
                check("b_drain_data", 32'(out_data_b), 32'(exp_b[nb]));
                check("b_drain_last", 32'(out_last_b), 32'(nb == DB - 1));
                nb++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        out_ready_b = 0;
        check("b_drain_lines", nb, DB);
        @(negedge clk);
        check("b_done", 32'(done_b), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
